// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: strobes one column at a time, debounces the full
// 16-key snapshot and reports each newly pressed key as a one-cycle event with its code.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [3:0]  key_col,
    output logic [15:0] key_map,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held
);

    // state | meaning
    // DRIVE | one column strobed low; rows sampled on the last settle cycle
    // EVAL  | all columns released; snapshot compared against the previous scan

    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] STABLE_MAX  = DW'(DEBOUNCE_SCANS - 1);

    typedef enum logic {DRIVE, EVAL} state_t;

    state_t        state, state_nxt;
    logic [1:0]    col, col_nxt;
    logic [SW-1:0] settle, settle_nxt;

    logic          sample_en;
    logic          eval_en;
    logic [3:0]    col_drive_nxt;

    logic [15:0]   raw;
    logic [15:0]   prev_raw;
    logic [DW-1:0] stable_cnt;
    logic [DW-1:0] stable_nxt;
    logic          map_load;
    logic [15:0]   new_keys;
    logic [3:0]    new_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DRIVE;
            col    <= 2'd0;
            settle <= '0;
        end else begin
            state  <= state_nxt;
            col    <= col_nxt;
            settle <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        settle_nxt = settle;
        case (state)
            DRIVE: begin
                if (settle == SETTLE_LAST) begin
                    settle_nxt = '0;
                    if (col == 2'd3) begin
                        state_nxt = EVAL;
                    end else begin
                        col_nxt = col + 2'd1;
                    end
                end else begin
                    settle_nxt = settle + SW'(1);
                end
            end
            EVAL: begin
                state_nxt = DRIVE;
                col_nxt   = 2'd0;
            end
            default: begin
                state_nxt  = DRIVE;
                col_nxt    = 2'd0;
                settle_nxt = '0;
            end
        endcase
    end

    // Strobe pattern is computed from the next state so key_col is a clean register
    always_comb begin
        sample_en     = (state == DRIVE) && (settle == SETTLE_LAST);
        eval_en       = (state == EVAL);
        col_drive_nxt = 4'b1111;
        if (state_nxt == DRIVE) begin
            col_drive_nxt = ~(4'b0001 << col_nxt);
        end
    end

    always_comb begin
        stable_nxt = '0;
        if (raw == prev_raw) begin
            stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + DW'(1);
        end
        map_load = eval_en && (stable_nxt == STABLE_MAX);
        new_keys = raw & ~key_map;
    end

    // Lowest set bit wins when several keys become pressed in the same scan
    always_comb begin
        new_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (new_keys[i]) new_code = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_col    <= 4'b1111;
            raw        <= '0;
            prev_raw   <= '0;
            stable_cnt <= '0;
            key_map    <= '0;
            key_valid  <= 1'b0;
            key_code   <= 4'd0;
        end else begin
            key_col   <= col_drive_nxt;
            key_valid <= 1'b0;
            if (sample_en) begin
                raw[{col, 2'b00} +: 4] <= ~key_row;
            end
            if (eval_en) begin
                stable_cnt <= stable_nxt;
                prev_raw   <= raw;
            end
            if (map_load) begin
                key_map <= raw;
                if (new_keys != 16'd0) begin
                    key_valid <= 1'b1;
                    key_code  <= new_code;
                end
            end
        end
    end

    assign key_held = |key_map;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix drives key_row from key_col,
// expected press codes are queued as keys are pressed and popped when key_valid pulses.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [15:0] key_map;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;

    logic [15:0] keys;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_map  (key_map),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; rows are pulled up otherwise
    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !key_col[c]) key_row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("pulse_code", 32'(key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    // Returns on the negedge inside the n-th EVAL cycle (strobe 0111 followed by 1111)
    task automatic wait_evals(input int n);
        logic [3:0] prev;
        int seen;
        int budget;
        prev   = key_col;
        seen   = 0;
        budget = n * 17 + 40;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (prev == 4'b0111 && key_col == 4'b1111) seen++;
            prev = key_col;
            budget--;
        end
        chk("eval_count", 32'(seen), 32'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("rst_col",   32'(key_col),   32'hF);
        chk("rst_map",   32'(key_map),   32'h0);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_code",  32'(key_code),  32'h0);
        chk("rst_held",  32'(key_held),  32'h0);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_col;
        int m;
        bit found;
        rst  = 1'b1;
        keys = 16'h0;

        // Idle scanning: strobe sequence, no events
        do_reset();
        for (int k = 1; k <= 170; k++) begin
            @(negedge clk);
            m = k % 17;
            exp_col = 4'b0001 << (m / 4);
            exp_col = (m == 16) ? 4'b1111 : ~exp_col;
            chk("idle_col", 32'(key_col), 32'(exp_col));
        end
        chk("idle_map", 32'(key_map), 32'h0);

        // Clean press of key 6 held from reset
        keys = 16'h0040;
        do_reset();
        exp_q.push_back(4'd6);
        wait_evals(2);
        @(negedge clk); #1;
        chk("press_map_early", 32'(key_map), 32'h0);
        chk("press_pending", 32'(exp_q.size()), 32'd1);
        wait_evals(1);
        @(negedge clk); #1;
        chk("press_valid", 32'(key_valid), 32'd1);
        chk("press_popped", 32'(exp_q.size()), 32'd0);
        chk("press_map", 32'(key_map), 32'h0040);
        chk("press_code", 32'(key_code), 32'd6);
        chk("press_held", 32'(key_held), 32'd1);
        @(negedge clk); #1;
        chk("press_valid_one", 32'(key_valid), 32'd0);

        // Release: map clears after three scans, no pulse, code held
        keys = 16'h0;
        wait_evals(2);
        @(negedge clk); #1;
        chk("rel_map_early", 32'(key_map), 32'h0040);
        wait_evals(1);
        @(negedge clk); #1;
        chk("rel_map", 32'(key_map), 32'h0);
        chk("rel_held", 32'(key_held), 32'd0);
        chk("rel_code", 32'(key_code), 32'd6);

        // Bounce: key present on alternate scans only
        for (int i = 0; i < 12; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0;
            wait_evals(1);
        end
        keys = 16'h0;
        @(negedge clk); #1;
        chk("bounce_map", 32'(key_map), 32'h0);
        chk("bounce_no_pulse", 32'(exp_q.size()), 32'd0);

        // Two keys in the same scan: lowest code reported once
        keys = 16'h0208;
        exp_q.push_back(4'd3);
        wait_evals(3);
        @(negedge clk); #1;
        chk("multi_map", 32'(key_map), 32'h0208);
        chk("multi_code", 32'(key_code), 32'd3);
        chk("multi_popped", 32'(exp_q.size()), 32'd0);

        // Adding a key reports only the new one
        keys = 16'h0209;
        exp_q.push_back(4'd0);
        wait_evals(3);
        @(negedge clk); #1;
        chk("add_map", 32'(key_map), 32'h0209);
        chk("add_code", 32'(key_code), 32'd0);
        wait_evals(2);
        @(negedge clk); #1;
        chk("add_popped", 32'(exp_q.size()), 32'd0);
        keys = 16'h0;
        wait_evals(3);
        @(negedge clk); #1;
        chk("add_release", 32'(key_map), 32'h0);

        // Reset while column 2 is driven with a key debounced
        keys = 16'h0040;
        exp_q.push_back(4'd6);
        wait_evals(3);
        @(negedge clk); #1;
        chk("pre_rst_map", 32'(key_map), 32'h0040);
        chk("pre_rst_popped", 32'(exp_q.size()), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (key_col == 4'b1011) found = 1'b1;
        end
        chk("col2_seen", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_col", 32'(key_col), 32'hF);
        chk("midrst_map", 32'(key_map), 32'h0);
        chk("midrst_held", 32'(key_held), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("restart_col0", 32'(key_col), 32'hE);
        exp_q.push_back(4'd6);
        wait_evals(2);
        @(negedge clk); #1;
        chk("rereport_early", 32'(key_map), 32'h0);
        chk("rereport_pending", 32'(exp_q.size()), 32'd1);
        wait_evals(1);
        @(negedge clk); #1;
        chk("rereport_map", 32'(key_map), 32'h0040);
        chk("rereport_popped", 32'(exp_q.size()), 32'd0);
        chk("rereport_code", 32'(key_code), 32'd6);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
